// File: rtl/cmac_tx_capture.sv
// -----------------------------------------------------------------------------
// cmac_tx_capture
//   Observes a 512-bit AXI-Stream transmit path and produces one 64-bit status
//   record per frame. Each record carries the frame length, error flags, a
//   sequence number and a 32-bit XOR checksum. Records are queued in a small
//   status FIFO. Running statistics counters are kept alongside.
//
// Parameters
//   MIN_PKT_LEN  frames shorter than this (bytes) are flagged runt
//   MAX_PKT_LEN  frames longer than this (bytes) are flagged oversize
//   STAT_DEPTH   status FIFO entries (power of two, >= 2)
//
// Ports
//   axis_aclk, axis_aresetn       clock, synchronous active-low reset
//   s_axis_tx_*                   frame beat input (valid/data/keep/last/
//                                 tuser_err) and tready back-pressure
//   m_axis_stat_*                 status record output stream
//                                 record: [15:0] len, [16] runt, [17] oversize,
//                                 [18] keep_err, [19] user_err, [31:20] seq,
//                                 [63:32] checksum
//   clear_stats                   zeroes the statistics counters
//   stat_pkt_count/byte/err       statistics counters
// -----------------------------------------------------------------------------
module cmac_tx_capture #(
  parameter int unsigned MIN_PKT_LEN = 64,
  parameter int unsigned MAX_PKT_LEN = 1518,
  parameter int unsigned STAT_DEPTH  = 4
) (
  input  logic         axis_aclk,
  input  logic         axis_aresetn,
  input  logic         s_axis_tx_tvalid,
  input  logic [511:0] s_axis_tx_tdata,
  input  logic [63:0]  s_axis_tx_tkeep,
  input  logic         s_axis_tx_tlast,
  input  logic         s_axis_tx_tuser_err,
  output logic         s_axis_tx_tready,
  output logic         m_axis_stat_tvalid,
  output logic [63:0]  m_axis_stat_tdata,
  input  logic         m_axis_stat_tready,
  input  logic         clear_stats,
  output logic [31:0]  stat_pkt_count,
  output logic [47:0]  stat_byte_count,
  output logic [31:0]  stat_err_count
);

  localparam int unsigned PW      = $clog2(STAT_DEPTH);
  localparam logic [15:0] MIN_LEN = 16'(MIN_PKT_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;
  logic        accept, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign s_axis_tx_tready = axis_aresetn && !fifo_full;
  assign accept           = s_axis_tx_tvalid && s_axis_tx_tready;
  assign push             = accept && s_axis_tx_tlast;

  // ---------------------------------------------------------------------------
  // Per-beat contributions
  // ---------------------------------------------------------------------------
  logic [6:0]   beat_bytes;
  logic [511:0] beat_masked;
  logic [31:0]  beat_csum;
  logic [63:0]  keep_plus1;
  logic         beat_keep_bad;

  always_comb begin
    beat_bytes  = '0;
    beat_masked = '0;
    beat_csum   = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      beat_bytes = beat_bytes + 7'(s_axis_tx_tkeep[i]);
      beat_masked[i*8 +: 8] = s_axis_tx_tkeep[i] ? s_axis_tx_tdata[i*8 +: 8] : 8'h00;
    end
    for (int unsigned w = 0; w < 16; w++) begin
      beat_csum = beat_csum ^ beat_masked[w*32 +: 32];
    end
  end

  // A last-beat keep is legal only when it is a non-empty run of ones from
  // bit 0: adding one to such a mask clears every set bit.
  assign keep_plus1 = s_axis_tx_tkeep + 64'd1;

  always_comb begin
    if (s_axis_tx_tlast) begin
      beat_keep_bad = (s_axis_tx_tkeep == '0) ||
                      ((s_axis_tx_tkeep & keep_plus1) != '0);
    end else begin
      beat_keep_bad = (s_axis_tx_tkeep != '1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame accumulation
  // ---------------------------------------------------------------------------
  logic [15:0] acc_len;
  logic        acc_keep_err;
  logic [31:0] acc_csum;

  logic [15:0] base_len;
  logic        base_keep_err;
  logic [31:0] base_csum;
  logic [16:0] len_sum;
  logic [15:0] frame_len;
  logic        frame_keep_err;
  logic [31:0] frame_csum;
  logic        frame_runt, frame_over;
  logic [3:0]  frame_flags;
  logic [11:0] seq_num;
  logic [63:0] record;

  // In IDLE the accumulators are ignored, so the first beat of a frame always
  // starts from zero regardless of what a previous frame left behind.
  always_comb begin
    base_len      = '0;
    base_keep_err = 1'b0;
    base_csum     = '0;
    if (state == IN_PKT) begin
      base_len      = acc_len;
      base_keep_err = acc_keep_err;
      base_csum     = acc_csum;
    end
  end

  assign len_sum        = {1'b0, base_len} + {10'd0, beat_bytes};
  assign frame_len      = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign frame_keep_err = base_keep_err | beat_keep_bad;
  assign frame_csum     = base_csum ^ beat_csum;
  assign frame_runt     = (frame_len < MIN_LEN);
  assign frame_over     = (frame_len > MAX_LEN);
  assign frame_flags    = {s_axis_tx_tuser_err, frame_keep_err, frame_over, frame_runt};
  assign record         = {frame_csum, seq_num, frame_flags, frame_len};

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      acc_len      <= '0;
      acc_keep_err <= 1'b0;
      acc_csum     <= '0;
    end else if (accept && !s_axis_tx_tlast) begin
      acc_len      <= frame_len;
      acc_keep_err <= frame_keep_err;
      acc_csum     <= frame_csum;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = s_axis_tx_tlast ? IDLE : IN_PKT;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence number (not affected by clear_stats)
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      seq_num <= '0;
    end else if (push) begin
      seq_num <= seq_num + 12'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status FIFO
  // ---------------------------------------------------------------------------
  logic [63:0] fifo_mem [STAT_DEPTH];

  assign m_axis_stat_tvalid = axis_aresetn && !fifo_empty;
  assign m_axis_stat_tdata  = m_axis_stat_tvalid ? fifo_mem[rd_ptr[PW-1:0]] : '0;
  assign pop                = m_axis_stat_tvalid && m_axis_stat_tready;

  always_ff @(posedge axis_aclk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= record;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters; clear wins over a coincident push
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn || clear_stats) begin
      stat_pkt_count  <= '0;
      stat_byte_count <= '0;
      stat_err_count  <= '0;
    end else if (push) begin
      stat_pkt_count  <= stat_pkt_count + 32'd1;
      stat_byte_count <= stat_byte_count + {32'd0, frame_len};
      stat_err_count  <= stat_err_count + {31'd0, |frame_flags};
    end
  end

endmodule
